// File: rtl/sa_credit_scheduler_if.sv
// Bundle of the switch-allocation request, credit-return, grant and crossbar-select signals.
// The scheduler connects through the slave modport; the input-block side drives through master.
interface sa_credit_scheduler_if #(
  parameter int unsigned PORT_NUM = 5,
  parameter int unsigned VC_NUM   = 2
);
  localparam int unsigned PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

  typedef logic [PW-1:0] port_t;

  logic  [PORT_NUM-1:0][VC_NUM-1:0]         request_i;
  port_t [PORT_NUM-1:0][VC_NUM-1:0]         out_port_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0][VW-1:0] down_vc_i;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]         credit_i;
  logic  [PORT_NUM-1:0]                     grant_valid_o;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]         granted_vc_o;
  logic  [PORT_NUM-1:0][PW-1:0]             xbar_sel_o;
  logic  [PORT_NUM-1:0]                     xbar_valid_o;
  logic  [PORT_NUM-1:0][VC_NUM-1:0]         credit_avail_o;
  logic                                     credit_err_o;

  modport master (
    output request_i, out_port_i, down_vc_i, credit_i,
    input  grant_valid_o, granted_vc_o, xbar_sel_o, xbar_valid_o, credit_avail_o, credit_err_o
  );

  modport slave (
    input  request_i, out_port_i, down_vc_i, credit_i,
    output grant_valid_o, granted_vc_o, xbar_sel_o, xbar_valid_o, credit_avail_o, credit_err_o
  );
endinterface

// File: rtl/sa_credit_scheduler.sv
// Credit-gated separable input-first switch allocator with iSLIP pointer update.
// Grants, crossbar selects and credit flags are registered: one-cycle allocation latency.
module sa_credit_scheduler #(
  parameter int unsigned PORT_NUM    = 5,
  parameter int unsigned VC_NUM      = 2,
  parameter int unsigned BUFFER_SIZE = 8
) (
  input logic                  clk,
  input logic                  rst,
  sa_credit_scheduler_if.slave bus
);
  localparam int unsigned PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam int unsigned VW = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;
  localparam int unsigned CW = $clog2(BUFFER_SIZE + 1);

  logic [PORT_NUM-1:0][VC_NUM-1:0][CW-1:0] cnt_q, cnt_d;
  logic [PORT_NUM-1:0][VW-1:0]             in_ptr_q, in_ptr_d;
  logic [PORT_NUM-1:0][PW-1:0]             out_ptr_q, out_ptr_d;
  logic [PORT_NUM-1:0]                     grant_valid_q, grant_valid_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         granted_vc_q, granted_vc_d;
  logic [PORT_NUM-1:0][PW-1:0]             xbar_sel_q, xbar_sel_d;
  logic [PORT_NUM-1:0]                     xbar_valid_q, xbar_valid_d;
  logic [PORT_NUM-1:0][VC_NUM-1:0]         credit_avail_q, credit_avail_d;
  logic                                    credit_err_q, credit_err_d;

  logic [PORT_NUM-1:0][VC_NUM-1:0] elig;
  logic [PORT_NUM-1:0]             nom_valid;
  logic [PORT_NUM-1:0][VW-1:0]     nom_vc;
  logic [PORT_NUM-1:0][PW-1:0]     nom_port;
  logic [PORT_NUM-1:0]             win_valid;
  logic [PORT_NUM-1:0][PW-1:0]     win_port;
  logic [PORT_NUM-1:0][VW-1:0]     win_dvc;
  logic [PORT_NUM-1:0][VC_NUM-1:0] dec;

  // Eligibility against current credits, then per-input round-robin VC nomination
  always_comb begin
    elig      = '0;
    nom_valid = '0;
    nom_vc    = '0;
    nom_port  = '0;
    for (int unsigned i = 0; i < PORT_NUM; i++) begin
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        if (bus.request_i[i][v] && (32'(bus.out_port_i[i][v]) < PORT_NUM))
          elig[i][v] = (cnt_q[bus.out_port_i[i][v]][bus.down_vc_i[i][v]] != '0);
      end
      for (int unsigned k = 0; k < VC_NUM; k++) begin
        if (!nom_valid[i] && elig[i][(32'(in_ptr_q[i]) + k) % VC_NUM]) begin
          nom_valid[i] = 1'b1;
          nom_vc[i]    = VW'((32'(in_ptr_q[i]) + k) % VC_NUM);
          nom_port[i]  = bus.out_port_i[i][(32'(in_ptr_q[i]) + k) % VC_NUM];
        end
      end
    end
  end

  // Per-output round-robin over nominating inputs
  always_comb begin
    win_valid = '0;
    win_port  = '0;
    win_dvc   = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      for (int unsigned k = 0; k < PORT_NUM; k++) begin
        if (!win_valid[p] && nom_valid[(32'(out_ptr_q[p]) + k) % PORT_NUM] &&
            (32'(nom_port[(32'(out_ptr_q[p]) + k) % PORT_NUM]) == p)) begin
          win_valid[p] = 1'b1;
          win_port[p]  = PW'((32'(out_ptr_q[p]) + k) % PORT_NUM);
          win_dvc[p]   = bus.down_vc_i[(32'(out_ptr_q[p]) + k) % PORT_NUM]
                                      [nom_vc[(32'(out_ptr_q[p]) + k) % PORT_NUM]];
        end
      end
    end
  end

  // Next-state: grants, pointer update on final grant only, credit accounting
  always_comb begin
    grant_valid_d  = '0;
    granted_vc_d   = '0;
    xbar_sel_d     = '0;
    xbar_valid_d   = win_valid;
    in_ptr_d       = in_ptr_q;
    out_ptr_d      = out_ptr_q;
    cnt_d          = cnt_q;
    credit_err_d   = credit_err_q;
    credit_avail_d = '0;
    dec            = '0;
    for (int unsigned p = 0; p < PORT_NUM; p++) begin
      if (win_valid[p]) begin
        xbar_sel_d[p]                            = win_port[p];
        grant_valid_d[win_port[p]]               = 1'b1;
        granted_vc_d[win_port[p]][nom_vc[win_port[p]]] = 1'b1;
        in_ptr_d[win_port[p]] = VW'((32'(nom_vc[win_port[p]]) + 1) % VC_NUM);
        out_ptr_d[p]          = PW'((32'(win_port[p]) + 1) % PORT_NUM);
      end
      for (int unsigned v = 0; v < VC_NUM; v++) begin
        dec[p][v] = win_valid[p] && (win_dvc[p] == VW'(v));
        if (dec[p][v] && !bus.credit_i[p][v]) begin
          cnt_d[p][v] = cnt_q[p][v] - CW'(1);
        end else if (!dec[p][v] && bus.credit_i[p][v]) begin
          if (cnt_q[p][v] == CW'(BUFFER_SIZE)) credit_err_d = 1'b1;
          else                                 cnt_d[p][v] = cnt_q[p][v] + CW'(1);
        end
        credit_avail_d[p][v] = (cnt_d[p][v] != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q          <= {(PORT_NUM * VC_NUM){CW'(BUFFER_SIZE)}};
      in_ptr_q       <= '0;
      out_ptr_q      <= '0;
      grant_valid_q  <= '0;
      granted_vc_q   <= '0;
      xbar_sel_q     <= '0;
      xbar_valid_q   <= '0;
      credit_avail_q <= '1;
      credit_err_q   <= 1'b0;
    end else begin
      cnt_q          <= cnt_d;
      in_ptr_q       <= in_ptr_d;
      out_ptr_q      <= out_ptr_d;
      grant_valid_q  <= grant_valid_d;
      granted_vc_q   <= granted_vc_d;
      xbar_sel_q     <= xbar_sel_d;
      xbar_valid_q   <= xbar_valid_d;
      credit_avail_q <= credit_avail_d;
      credit_err_q   <= credit_err_d;
    end
  end

  assign bus.grant_valid_o  = grant_valid_q;
  assign bus.granted_vc_o   = granted_vc_q;
  assign bus.xbar_sel_o     = xbar_sel_q;
  assign bus.xbar_valid_o   = xbar_valid_q;
  assign bus.credit_avail_o = credit_avail_q;
  assign bus.credit_err_o   = credit_err_q;
endmodule

// File: tb/tb_sa_credit_scheduler.sv
// Directed bench for sa_credit_scheduler: credit exhaustion/return, rotation,
// iSLIP pointer behaviour, credit overflow flag and mid-traffic reset.
module tb_sa_credit_scheduler;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  int   n_fail;
  int   ngr;

  sa_credit_scheduler_if #(.PORT_NUM(5), .VC_NUM(2)) bus ();

  sa_credit_scheduler #(.PORT_NUM(5), .VC_NUM(2), .BUFFER_SIZE(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bus.request_i  = '0;
    bus.out_port_i = '0;
    bus.down_vc_i  = '0;
    bus.credit_i   = '0;
  endtask

  task automatic do_reset();
    clr();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; n_fail = 0;
    clr();
    rst = 1'b1;
    tick();
    tick();
    chk("rst_gv",    64'(bus.grant_valid_o),  64'h0);
    chk("rst_gvc",   64'(bus.granted_vc_o),   64'h0);
    chk("rst_xsel",  64'(bus.xbar_sel_o),     64'h0);
    chk("rst_xv",    64'(bus.xbar_valid_o),   64'h0);
    chk("rst_avail", 64'(bus.credit_avail_o), 64'h3FF);
    chk("rst_err",   64'(bus.credit_err_o),   64'h0);
    rst = 1'b0;

    // Single requester exhausting counter(2,0)
    bus.request_i[0][1]  = 1'b1;
    bus.out_port_i[0][1] = 3'd2;
    bus.down_vc_i[0][1]  = 1'b0;
    tick();
    chk("a_gv",   64'(bus.grant_valid_o),   64'b00001);
    chk("a_gvc",  64'(bus.granted_vc_o[0]), 64'b10);
    chk("a_xsel", 64'(bus.xbar_sel_o[2]),   64'd0);
    chk("a_xv",   64'(bus.xbar_valid_o),    64'b00100);
    ngr = 1;
    for (int n = 0; n < 7; n++) begin
      tick();
      if (bus.grant_valid_o[0]) ngr++;
    end
    chk("a_8grants", 64'(ngr), 64'd8);
    chk("a_avail0",  64'(bus.credit_avail_o[2][0]), 64'd0);
    tick();
    chk("a_stop_gv", 64'(bus.grant_valid_o), 64'h0);
    chk("a_stop_xv", 64'(bus.xbar_valid_o),  64'h0);

    // One credit back -> exactly one more grant
    bus.credit_i[2][0] = 1'b1;
    tick();
    bus.credit_i[2][0] = 1'b0;
    chk("b_cr_gv",    64'(bus.grant_valid_o), 64'h0);
    chk("b_cr_avail", 64'(bus.credit_avail_o[2][0]), 64'd1);
    tick();
    chk("b_one_gv", 64'(bus.grant_valid_o), 64'b00001);
    tick();
    chk("b_none_gv", 64'(bus.grant_valid_o), 64'h0);

    // Credit and grant on the same edge hold the counter
    bus.credit_i[2][0] = 1'b1;
    tick();
    chk("c_load_gv", 64'(bus.grant_valid_o), 64'h0);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("c_hold_gv",    64'(bus.grant_valid_o), 64'b00001);
      chk("c_hold_avail", 64'(bus.credit_avail_o[2][0]), 64'd1);
    end
    bus.credit_i[2][0] = 1'b0;
    tick();
    chk("c_last_gv",    64'(bus.grant_valid_o), 64'b00001);
    chk("c_last_avail", 64'(bus.credit_avail_o[2][0]), 64'd0);
    tick();
    chk("c_end_gv", 64'(bus.grant_valid_o), 64'h0);

    // Inputs 0,1,3 contend for output 4: rotation 0,1,3,0,1,3
    do_reset();
    bus.request_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd4;
    bus.request_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd4;
    bus.request_i[3][0] = 1'b1; bus.out_port_i[3][0] = 3'd4;
    for (int r = 0; r < 2; r++) begin
      tick();
      chk("d_gv_0",  64'(bus.grant_valid_o), 64'b00001);
      chk("d_sel_0", 64'(bus.xbar_sel_o[4]), 64'd0);
      tick();
      chk("d_gv_1",  64'(bus.grant_valid_o), 64'b00010);
      chk("d_sel_1", 64'(bus.xbar_sel_o[4]), 64'd1);
      tick();
      chk("d_gv_3",  64'(bus.grant_valid_o), 64'b01000);
      chk("d_sel_3", 64'(bus.xbar_sel_o[4]), 64'd3);
      chk("d_xv",    64'(bus.xbar_valid_o),  64'b10000);
    end

    // Stage-2 loss must not advance in_ptr
    do_reset();
    bus.request_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd1; bus.down_vc_i[1][0] = 1'b1;
    tick();
    chk("e_prime_gv", 64'(bus.grant_valid_o), 64'b00010);
    clr();
    bus.request_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd1; bus.down_vc_i[0][0] = 1'b0;
    bus.request_i[0][1] = 1'b1; bus.out_port_i[0][1] = 3'd2; bus.down_vc_i[0][1] = 1'b0;
    bus.request_i[2][0] = 1'b1; bus.out_port_i[2][0] = 3'd1; bus.down_vc_i[2][0] = 1'b1;
    tick();
    chk("e_c2_gv",   64'(bus.grant_valid_o), 64'b00100);
    chk("e_c2_sel1", 64'(bus.xbar_sel_o[1]), 64'd2);
    chk("e_c2_xv",   64'(bus.xbar_valid_o),  64'b00010);
    tick();
    chk("e_c3_gv",   64'(bus.grant_valid_o),   64'b00001);
    chk("e_c3_gvc",  64'(bus.granted_vc_o[0]), 64'b01);
    chk("e_c3_sel1", 64'(bus.xbar_sel_o[1]),   64'd0);
    tick();
    chk("e_c4_gv",   64'(bus.grant_valid_o),   64'b00101);
    chk("e_c4_gvc",  64'(bus.granted_vc_o[0]), 64'b10);
    chk("e_c4_sel1", 64'(bus.xbar_sel_o[1]),   64'd2);
    chk("e_c4_sel2", 64'(bus.xbar_sel_o[2]),   64'd0);
    chk("e_c4_xv",   64'(bus.xbar_valid_o),    64'b00110);

    // Credit returned to a full counter: sticky error, counter saturates at 8
    do_reset();
    bus.credit_i[3][1] = 1'b1;
    tick();
    bus.credit_i[3][1] = 1'b0;
    chk("f_err_set", 64'(bus.credit_err_o), 64'd1);
    chk("f_avail",   64'(bus.credit_avail_o), 64'h3FF);
    bus.request_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd3; bus.down_vc_i[0][0] = 1'b1;
    ngr = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (bus.grant_valid_o[0]) ngr++;
    end
    chk("f_sat_grants", 64'(ngr), 64'd8);
    chk("f_avail31",    64'(bus.credit_avail_o[3][1]), 64'd0);
    chk("f_err_sticky", 64'(bus.credit_err_o), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("f_err_clr", 64'(bus.credit_err_o), 64'd0);

    // Reset in the middle of traffic: counter(1,0)=3, out_ptr[1]=1 beforehand
    do_reset();
    bus.request_i[0][0] = 1'b1; bus.out_port_i[0][0] = 3'd1;
    bus.request_i[1][0] = 1'b1; bus.out_port_i[1][0] = 3'd1;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("g_alt_gv", 64'(bus.grant_valid_o), (n % 2 == 0) ? 64'b00001 : 64'b00010);
    end
    rst = 1'b1;
    tick();
    chk("g_rst_gv",    64'(bus.grant_valid_o),  64'h0);
    chk("g_rst_gvc",   64'(bus.granted_vc_o),   64'h0);
    chk("g_rst_xv",    64'(bus.xbar_valid_o),   64'h0);
    chk("g_rst_avail", 64'(bus.credit_avail_o), 64'h3FF);
    rst = 1'b0;
    tick();
    chk("g_post_gv",  64'(bus.grant_valid_o), 64'b00001);
    chk("g_post_sel", 64'(bus.xbar_sel_o[1]), 64'd0);
    ngr = 1;
    for (int n = 0; n < 9; n++) begin
      tick();
      if (bus.grant_valid_o != '0) ngr++;
    end
    chk("g_post_credits", 64'(ngr), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sa_credit_scheduler.md
Name: sa_credit_scheduler

Overview:
- Credit-aware switch-allocation scheduler that arbitrates the crossbar between input-port VCs and drives grants to the input buffers and crossbar.
- Two-stage separable input-first allocation, iSLIP-style pointer update, gated by per-(output port, downstream VC) credit counters.
- Sits between the input-block VC state and the crossbar.
- Outputs are registered, giving one-cycle allocation latency.

Parameters:
- PORT_NUM, 5, number of router ports, both input and output.
- VC_NUM, 2, VCs per port.
- BUFFER_SIZE, 8, downstream buffer depth per VC; also the initial credit value.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- request_i  input  [PORT_NUM-1:0][VC_NUM-1:0]  VC v of input port i has a flit ready for switch allocation.
- out_port_i  input  port_t [PORT_NUM-1:0][VC_NUM-1:0]  requested output port index, width $clog2(PORT_NUM).
- down_vc_i  input  [PORT_NUM-1:0][VC_NUM-1:0][$clog2(VC_NUM)-1:0]  downstream VC already allocated to that input VC.
- credit_i  input  [PORT_NUM-1:0][VC_NUM-1:0]  one credit returned for output port p, downstream VC v.
- grant_valid_o  output  [PORT_NUM-1:0]  input port i won this cycle.
- granted_vc_o  output  [PORT_NUM-1:0][VC_NUM-1:0]  one-hot winning VC per input port; all zero when there is no grant.
- xbar_sel_o  output  [PORT_NUM-1:0][$clog2(PORT_NUM)-1:0]  input port index driving output port p.
- xbar_valid_o  output  [PORT_NUM-1:0]  output port p carries a flit.
- credit_avail_o  output  [PORT_NUM-1:0][VC_NUM-1:0]  registered flag: counter(p,v) is nonzero.
- credit_err_o  output  1  sticky flag: a credit returned to a full counter.

Behaviour:
Reset:
- All outputs are 0, except credit_avail_o, which is all 1.
- Credit counters are set to BUFFER_SIZE. Counter width is $clog2(BUFFER_SIZE+1).
- All round-robin pointers are set to 0.
- Reset mid-operation discards any in-flight grant; the next cycle's outputs are the reset values.

Eligibility:
- Input VC (i,v) is eligible when request_i[i][v]=1 and counter(out_port_i[i][v], down_vc_i[i][v]) > 0.
- Eligibility is evaluated on the current counter values.

Stage 1 (per input port i):
- Round-robin over the eligible VCs, with search starting at pointer in_ptr[i].
- The winner nominates its output port.

Stage 2 (per output port p):
- Round-robin over the nominating input ports, with search starting at pointer out_ptr[p].

Pointer update (iSLIP):
- Update only for a final grant.
- in_ptr[i] becomes winner_vc+1 mod VC_NUM.
- out_ptr[p] becomes winner_port+1 mod PORT_NUM.
- A stage-1 nominee that loses stage 2 leaves in_ptr[i] unchanged.

Register stage:
- Final grants are registered at the clock edge, so outputs are valid one cycle after the requesting cycle.
- Grant outputs are held for exactly one cycle and are recomputed every cycle.
- The requester must deassert or keep requesting as its own state dictates; there is no hold.

Credit counters:
- On the same edge that registers a grant to (p,v), counter(p,v) decrements.
- The next cycle's eligibility therefore sees the reduced count, which prevents double-booking when count=1.
- Grant and credit_i to the same (p,v) on the same edge leave the counter unchanged.
- Multiple grants to the same (p,v) in one cycle are impossible, because stage 2 gives one grant per output port.
- A counter never underflows, because a counter at 0 makes its requesters ineligible.
- credit_i at counter=BUFFER_SIZE with no simultaneous grant: the counter saturates and credit_err_o sets. credit_err_o clears only on rst.

Output invariants:
- A U-turn (out_port_i equal to the input port) is legal and treated like any other port.
- Each output port has at most one grant.
- Each input port has at most one grant.
- xbar_valid_o[p]=1 if and only if some grant_valid_o[i] targets p.

Test Plan:
- Reset, then a single request (port 0, VC 1, out 2, down_vc 0) held high.
  - Cycle+1: grant_valid_o[0]=1, granted_vc_o[0]=2'b10, xbar_sel_o[2]=0, xbar_valid_o[2]=1.
  - After 8 grants, counter(2,0)=0, credit_avail_o[2][0]=0, and no further grants.
- Continuing the previous case with credit_i[2][0] pulsed for 1 cycle: exactly one more grant follows. Then pulse credit_i and hold the request together: the counter stays constant.
- Inputs 0, 1 and 3 all request output 4 continuously with ample credits: grants rotate 0, 1, 3, 0, 1, 3. out_ptr[4] advances past each winner.
- Input 0 with VC0 and VC1 both requesting (VC0 to out 1, VC1 to out 2) while input 2 persistently wins out 1:
  - in_ptr[0] does not advance on VC0's stage-2 loss.
  - VC1 is granted only when the pointer reaches it after a VC0 win.
- credit_i[3][1] pulsed at full counter: credit_err_o=1 from the next cycle, counter stays 8, and rst clears the flag.
- Counter(1,0)=3 with traffic active, then rst asserted for one cycle:
  - Next cycle: all grants 0, counters 8, pointers 0.
  - The first post-reset arbitration favours the lowest indices.
